ialm_arb: RTL and testbench
===========================

IALM_ARB -- requirements
Module: ialm_arb

Interface
REQ-001 Parameter: NREQ, default 4, number of requesters (2..8).
REQ-002 Parameter: W, default 16, operand width; the result is 2*W bits wide.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous and active-high.
REQ-005 Port: req_valid  input  NREQ  per-requester operand valid.
REQ-006 Port: req_ready  output  NREQ  per-requester accept; at most one bit set per cycle.
REQ-007 Port: req_a  input  NREQ*W  flattened multiplicands; requester i occupies bits [i*W +: W].
REQ-008 Port: req_b  input  NREQ*W  flattened multipliers, packed the same way.
REQ-009 Port: out_valid  output  1  product valid.
REQ-010 Port: out_ready  input  1  downstream accept.
REQ-011 Port: out_result  output  2*W  approximate product.
REQ-012 Port: out_id  output  clog2(NREQ)  index of the requester that owns out_result.
REQ-013 Port: busy  output  1  high while either pipeline stage holds valid data.
REQ-014 Port: stat_clr  input  1  synchronous clear of the statistics counters.
REQ-015 Port: stat_cnt  output  NREQ*16  flattened per-requester grant counters.

Function
REQ-016 Shall share one combinational W x W approximate log multiplier core (ports a, b, result) among all requesters.
REQ-017 Shall have a 2-stage pipeline:
- S1 registers a, b and id.
- The core is evaluated combinationally from S1.
- S2 registers result and id; S2 drives the out_* ports.
REQ-018 S2 loads when it is empty or when out_valid & out_ready; S1 loads when it is empty or when S1 moves to S2.
REQ-019 Arbitration shall be round-robin: the search starts at pointer ptr, and the first i with req_valid[i] wins.
REQ-020 req_ready[i] = (i is the winner) & (S1 can load); a transfer is req_valid[i] & req_ready[i].
REQ-021 After each transfer, ptr = (winner+1) mod NREQ; with no transfer, ptr holds.
REQ-022 Latency: a transfer at edge N gives out_valid at edge N+1 (S1) and N+2 (S2) when there is no backpressure.
- Sustained throughput is 1 product per cycle.
REQ-023 While out_valid=1 and out_ready=0, out_result and out_id shall hold stable; at most 2 operations are in flight, then req_ready is all zero.
REQ-024 out_valid shall not depend combinationally on out_ready; req_ready may depend on req_valid and out_ready.
REQ-025 If either operand is 0, the result shall be 0, in every mode.
REQ-026 Requesters shall hold req_valid and their operands stable until accepted; the block shall not reorder results (FIFO order).
REQ-027 With no req_valid asserted, no transfer occurs, ptr holds, and the pipeline drains normally.

Reset
REQ-028 rst asserted, at any time including mid-operation, shall immediately:
- clear the S1/S2 valid bits;
- set out_valid=0, req_ready=0, busy=0 and ptr=0;
- set out_result=0 and out_id=0;
- set all stat counters to 0.
In-flight operations are discarded.
REQ-029 After rst deasserts, the first edge may accept a request.

Configuration
REQ-030 Macro IALM_ARB_STATS_EN selects the statistics feature.
REQ-031 When defined:
- stat_cnt[i] increments on each transfer of requester i and saturates at 0xFFFF.
- stat_clr=1 zeroes all counters; if clear and increment occur on the same edge, the clear wins.
REQ-032 When undefined: the ports remain, stat_cnt is constant 0, stat_clr is ignored, and no counter flops are built.

Structure
REQ-033 The shared package ialm_pkg shall hold the W default, the NREQ maximum, the id-width function, the stage record typedef (valid, a, b, id) and the counter width (16).
REQ-034 One sub-module, ialm_rr_arb (round-robin grant plus pointer), is natural; the multiplier core is instantiated unmodified.

Verification
REQ-035 Single request: req0 sends a=0, b=5 -> out_result=0, out_id=0, out_valid 2 edges after the transfer.
REQ-036 Powers of two: req2 sends a=2, b=4 -> 8; a=16'h8000, b=2 -> 32'h0001_0000; all out_id=2.
REQ-037 All NREQ=4 requesters hold valid for 8 cycles with out_ready=1 -> grant order 0,1,2,3,0,1,2,3, one transfer per cycle.
REQ-038 out_ready=0 for 5 cycles -> exactly 2 transfers accepted, then req_ready=0; out_result stays stable, and the queued results drain in order once out_ready=1.
REQ-039 rst pulse while both stages are valid -> out_valid=0 and busy=0 immediately; the next grant goes to the lowest valid requester from ptr=0.
REQ-040 With IALM_ARB_STATS_EN, 70000 transfers from req1 -> stat_cnt[1]=0xFFFF; stat_clr -> 0; the same edge as an increment -> 0.

Source files
------------

// File: rtl/ialm_pkg.sv
// Shared definitions for the ialm_arb shared approximate-multiplier arbiter.
package ialm_pkg;

  localparam int unsigned WDefault = 16;
  localparam int unsigned NReqMax  = 8;
  localparam int unsigned CntW     = 16;
  // Widest operand a stage record can carry; instances must keep W <= StageW.
  localparam int unsigned StageW   = 32;

  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned IdMaxW = id_width(NReqMax);

  typedef struct packed {
    logic              valid;
    logic [StageW-1:0] a;
    logic [StageW-1:0] b;
    logic [IdMaxW-1:0] id;
  } stage_t;

endpackage

// File: rtl/ialm_core.sv
// Combinational W x W Mitchell logarithmic multiplier; zero in, zero out.
module ialm_core #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] result
);

  localparam int unsigned RW = 2 * W;
  localparam int unsigned KW = $clog2(W) + 1;

  logic [KW-1:0] ka, kb;
  logic [RW-1:0] xa, xb, sum, base;

  always_comb begin
    ka = '0;
    kb = '0;
    for (int i = 0; i < W; i++) begin
      if (a[i]) ka = KW'(i);
      if (b[i]) kb = KW'(i);
    end
    // Mantissas with the leading one stripped, aligned so sum/base share one scale.
    xa   = RW'(a) & ~(RW'(1) << ka);
    xb   = RW'(b) & ~(RW'(1) << kb);
    sum  = (xa << kb) + (xb << ka);
    base = RW'(1) << (ka + kb);
    if (a == '0 || b == '0) begin
      result = '0;
    end else if (sum < base) begin
      result = base + sum;
    end else begin
      result = sum << 1;
    end
  end

endmodule

// File: rtl/ialm_rr_arb.sv
// Round-robin grant: search starts at ptr, ptr moves past the winner on each transfer.
module ialm_rr_arb
  import ialm_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IdW  = id_width(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IdW-1:0]  grant_id,
  output logic            grant_any
);

  localparam logic [IdW:0] NReqL = (IdW + 1)'(NREQ);

  logic [IdW-1:0] ptr_q;
  logic [IdW:0]   idx;

  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    idx       = '0;
    for (int j = 0; j < NREQ; j++) begin
      idx = {1'b0, ptr_q} + (IdW + 1)'(j);
      if (idx >= NReqL) idx = idx - NReqL;
      if (!grant_any && req[idx[IdW-1:0]]) begin
        grant_any = 1'b1;
        grant_id  = idx[IdW-1:0];
      end
    end
    if (grant_any) grant[grant_id] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= (grant_id == IdW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/ialm_arb.sv
// NREQ requesters share one approximate multiplier through a 2-stage pipeline.
// Define IALM_ARB_STATS_EN to build the per-requester saturating grant counters.
module ialm_arb
  import ialm_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
  parameter  int unsigned W    = WDefault,
  localparam int unsigned IdW  = id_width(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*W-1:0]    req_a,
  input  logic [NREQ*W-1:0]    req_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*W-1:0]       out_result,
  output logic [IdW-1:0]       out_id,
  output logic                 busy,
  input  logic                 stat_clr,
  output logic [NREQ*CntW-1:0] stat_cnt
);

  stage_t         s1_q;
  logic           s2_valid_q;
  logic [2*W-1:0] s2_result_q;
  logic [IdW-1:0] s2_id_q;

  logic [NREQ-1:0] grant;
  logic [IdW-1:0]  grant_id;
  logic            grant_any;
  logic            s1_load, s2_load, xfer;
  logic [2*W-1:0]  core_result;

  assign s2_load = !s2_valid_q || out_ready;
  assign s1_load = !s1_q.valid || s2_load;
  // Gated by rst so nothing is offered while reset is held.
  assign xfer      = grant_any && s1_load && !rst;
  assign req_ready = xfer ? grant : '0;

  ialm_rr_arb #(
    .NREQ (NREQ)
  ) u_rr_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .advance   (xfer),
    .grant     (grant),
    .grant_id  (grant_id),
    .grant_any (grant_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
    end else if (s1_load) begin
      s1_q.valid <= xfer;
      if (xfer) begin
        s1_q.a  <= StageW'(req_a[grant_id*W +: W]);
        s1_q.b  <= StageW'(req_b[grant_id*W +: W]);
        s1_q.id <= IdMaxW'(grant_id);
      end
    end
  end

  ialm_core #(
    .W (W)
  ) u_core (
    .a      (s1_q.a[W-1:0]),
    .b      (s1_q.b[W-1:0]),
    .result (core_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_id_q     <= '0;
    end else if (s2_load) begin
      s2_valid_q <= s1_q.valid;
      if (s1_q.valid) begin
        s2_result_q <= core_result;
        s2_id_q     <= s1_q.id[IdW-1:0];
      end
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = s2_result_q;
  assign out_id     = s2_id_q;
  assign busy       = s1_q.valid || s2_valid_q;

  // The stage record is sized for the widest build; spare upper bits are don't-care.
  logic unused_stage;
  assign unused_stage = ^{s1_q.a, s1_q.b, s1_q.id};

`ifdef IALM_ARB_STATS_EN
  logic [CntW-1:0] cnt_q [NREQ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (stat_clr) begin
          cnt_q[i] <= '0;
        end else if (req_valid[i] && req_ready[i] && cnt_q[i] != '1) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_stat
    assign stat_cnt[g*CntW +: CntW] = cnt_q[g];
  end
`else
  assign stat_cnt = '0;
  logic unused_stat;
  assign unused_stat = stat_clr;
`endif

endmodule

// File: tb/tb_ialm_arb.sv
// Scoreboard bench for ialm_arb: random traffic checked against a log-domain reference model.
module tb_ialm_arb;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned W     = 16;
  localparam int unsigned RW    = 2 * W;
  localparam int unsigned IdW   = 2;
  localparam int unsigned CntW  = 16;
  localparam int unsigned Depth = 64;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*W-1:0]    req_a, req_b;
  logic                 out_valid, out_ready;
  logic [RW-1:0]        out_result;
  logic [IdW-1:0]       out_id;
  logic                 busy;
  logic                 stat_clr;
  logic [NREQ*CntW-1:0] stat_cnt;

  always #5 clk = ~clk;

  ialm_arb #(
    .NREQ (NREQ),
    .W    (W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_id     (out_id),
    .busy       (busy),
    .stat_clr   (stat_clr),
    .stat_cnt   (stat_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: Mitchell's rule in the log domain, log2(v) ~ k + (v - 2^k) / 2^k.
  function automatic real log_approx(input logic [W-1:0] v);
    int k;
    k = 0;
    while ((v >> (k + 1)) != 0) k++;
    return real'(k) + (real'(v) - 2.0 ** k) / (2.0 ** k);
  endfunction

  function automatic logic [RW-1:0] model_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    real l, fr;
    int  ip;
    if (a == 0 || b == 0) return '0;
    l  = log_approx(a) + log_approx(b);
    ip = int'($floor(l));
    fr = l - real'(ip);
    return RW'(longint'((1.0 + fr) * (2.0 ** ip)));
  endfunction

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return W'(1) << $urandom_range(0, W - 1);
      2:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  // Per-requester operand tables feeding the driver.
  logic [W-1:0]    op_a [NREQ][Depth];
  logic [W-1:0]    op_b [NREQ][Depth];
  int              wr_ptr [NREQ];
  int              rd_ptr [NREQ];
  logic [NREQ-1:0] acc;
  int              rdy_mode;
  bit              flood;

  task automatic push_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    op_a[i][wr_ptr[i] % Depth] = a;
    op_b[i][wr_ptr[i] % Depth] = b;
    wr_ptr[i]++;
  endtask

  // Driver: updates requester inputs and out_ready just after each rising edge.
  initial begin
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    out_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      wr_ptr[i] = 0;
      rd_ptr[i] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (rst) begin
          rd_ptr[i]    = wr_ptr[i];
          req_valid[i] = 1'b0;
        end else begin
          if (acc[i] && rd_ptr[i] < wr_ptr[i]) rd_ptr[i]++;
          if (flood && i == 1) begin
            if (acc[i] || !req_valid[i]) begin
              req_a[i*W +: W] = rand_op();
              req_b[i*W +: W] = rand_op();
              req_valid[i]    = 1'b1;
            end
          end else if (rd_ptr[i] < wr_ptr[i]) begin
            req_a[i*W +: W] = op_a[i][rd_ptr[i] % Depth];
            req_b[i*W +: W] = op_b[i][rd_ptr[i] % Depth];
            req_valid[i]    = 1'b1;
          end else begin
            req_valid[i] = 1'b0;
          end
        end
      end
      acc = '0;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  typedef struct {
    logic [RW-1:0]  res;
    logic [IdW-1:0] id;
    int             acc_cyc;
  } exp_t;

  exp_t            exp_q[$];
  exp_t            e;
  int              cyc = 0;
  int              last_pop = -1;
  int              m_ptr = 0;
  logic [CntW-1:0] m_cnt [NREQ];

  // Monitor/scoreboard: samples mid-cycle, predicts the coming edge from the model.
  initial begin
    for (int i = 0; i < NREQ; i++) m_cnt[i] = '0;
    acc = '0;
    forever begin
      int                   n, winner, idx;
      bit                   ov_exp, can;
      logic [NREQ-1:0]      exp_rdy;
      logic [NREQ*CntW-1:0] exp_cnt;
      @(negedge clk);
      cyc++;
      for (int i = 0; i < NREQ; i++) exp_cnt[i*CntW +: CntW] = m_cnt[i];
      if (rst) begin
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_id", out_id, 0);
        check("rst_stat_cnt", stat_cnt, 0);
        exp_q.delete();
        m_ptr    = 0;
        last_pop = -1;
        acc      = '0;
      end else begin
        check("stat_cnt", stat_cnt, exp_cnt);
        n      = exp_q.size();
        ov_exp = 1'b0;
        if (n > 0) ov_exp = (cyc >= exp_q[0].acc_cyc + 2) && (cyc >= last_pop + 1);
        check("out_valid", out_valid, ov_exp);
        check("busy", busy, n > 0);
        if (ov_exp) begin
          check("out_result", out_result, exp_q[0].res);
          check("out_id", out_id, exp_q[0].id);
        end
        winner = -1;
        for (int j = 0; j < NREQ; j++) begin
          idx = (m_ptr + j) % NREQ;
          if (winner < 0 && req_valid[idx]) winner = idx;
        end
        can     = (n < 2) || out_ready;
        exp_rdy = '0;
        if (winner >= 0 && can) exp_rdy[winner] = 1'b1;
        check("req_ready", req_ready, exp_rdy);
        acc = acc | (req_valid & req_ready);
`ifdef IALM_ARB_STATS_EN
        for (int i = 0; i < NREQ; i++) begin
          if (stat_clr) m_cnt[i] = '0;
          else if (exp_rdy[i] && m_cnt[i] != '1) m_cnt[i] = m_cnt[i] + 1'b1;
        end
`endif
        if (ov_exp && out_ready) begin
          void'(exp_q.pop_front());
          last_pop = cyc;
        end
        if (winner >= 0 && can) begin
          e.res     = model_mul(req_a[winner*W +: W], req_b[winner*W +: W]);
          e.id      = IdW'(winner);
          e.acc_cyc = cyc;
          exp_q.push_back(e);
          m_ptr = (winner + 1) % NREQ;
        end
      end
    end
  end

  task automatic step(input int cycles);
    repeat (cycles) @(posedge clk);
    #2;
  endtask

  function automatic bit idle();
    for (int i = 0; i < NREQ; i++) if (rd_ptr[i] < wr_ptr[i]) return 1'b0;
    return exp_q.size() == 0;
  endfunction

  task automatic drain(input string name, input int budget);
    int k;
    k = 0;
    while (k < budget && !idle()) begin
      step(1);
      k++;
    end
    check(name, idle(), 1);
    step(2);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    stat_clr = 1'b0;
    rdy_mode = 0;
    flood    = 1'b0;
    step(3);
    rst = 1'b0;
    step(1);

    // Zero operand, then exact powers of two.
    push_op(0, 16'd0, 16'd5);
    drain("drain_single", 50);
    push_op(2, 16'd2, 16'd4);
    push_op(2, 16'h8000, 16'd2);
    drain("drain_pow2", 50);

    // All requesters contending: strict rotation, one transfer per cycle.
    for (int i = 0; i < NREQ; i++) begin
      push_op(i, rand_op(), rand_op());
      push_op(i, rand_op(), rand_op());
    end
    drain("drain_rr", 50);

    // Output stalled: two in flight, then everything waits.
    rdy_mode = 2;
    for (int i = 0; i < NREQ; i++) begin
      push_op(i, rand_op(), rand_op());
      push_op(i, rand_op(), rand_op());
    end
    step(6);
    rdy_mode = 0;
    drain("drain_stall", 100);

    // Random bursts with random backpressure and idle gaps.
    rdy_mode = 1;
    repeat (30) begin
      for (int i = 0; i < NREQ; i++) begin
        repeat ($urandom_range(0, 6)) push_op(i, rand_op(), rand_op());
      end
      drain("drain_random", 400);
    end

    // Reset while both stages hold data.
    rdy_mode = 2;
    for (int i = 0; i < NREQ; i++) begin
      push_op(i, rand_op(), rand_op());
      push_op(i, rand_op(), rand_op());
    end
    step(4);
    check("pre_rst_busy", busy, 1);
    check("pre_rst_out_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_req_ready", req_ready, 0);
    check("async_rst_out_result", out_result, 0);
    step(2);
    rst      = 1'b0;
    rdy_mode = 0;
    push_op(3, 16'd3, 16'd7);
    push_op(1, 16'd9, 16'd11);
    drain("drain_post_rst", 50);

`ifdef IALM_ARB_STATS_EN
    // Saturation, clear racing an increment, then a plain clear.
    flood = 1'b1;
    step(70005);
    check("stat_sat", stat_cnt[1*CntW +: CntW], 16'hFFFF);
    stat_clr = 1'b1;
    step(1);
    stat_clr = 1'b0;
    flood    = 1'b0;
    drain("drain_flood", 50);
    push_op(1, 16'd5, 16'd6);
    drain("drain_cnt", 50);
    stat_clr = 1'b1;
    step(1);
    stat_clr = 1'b0;
    step(1);
    check("stat_clr_final", stat_cnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
